mail_drop_sequencer: RTL and testbench
======================================

MAIL_DROP_SEQUENCER -- requirements
Module: mail_drop_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 100_000_000, sets the clk cycles a servo holds its drop angle.
REQ-002 Parameter SETTLE_CYCLES, default 50_000_000, sets the clk cycles a servo holds stationary after a drop, before the next action.
REQ-003 clk  input  1  system clock, 100 MHz; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse: rover is halted at a delivery stop.
REQ-006 req_left  input  2  left-side mail code: 00 none, 01 10 Hz, 10 100 Hz, 11 1 kHz.
REQ-007 req_right  input  2  right-side mail code, same encoding.
REQ-008 pos_10, pos_100, pos_1k  output  18 each  servo pulse width in clk counts, driven to the PWM generator.
REQ-009 busy  output  1  high while a delivery sequence runs.
REQ-010 done  output  1  one-cycle pulse when a sequence ends.
REQ-011 go  output  1  level; rover is permitted to drive.
REQ-012 conflict  output  1  sticky flag; left and right requested the same non-none code.

Function
REQ-013 The block SHALL use pulse constants STATIONARY=150000, RIGHT_SIDE=205000 and LEFT_SIDE=100000.
REQ-014 States: IDLE, DROP_L, SETTLE_L, DROP_R, SETTLE_R, DONE.
REQ-015 IDLE + start: latch req_left/req_right, go<=0, busy<=1, go to DROP_L. If the left code is none, go to DROP_R instead. If both codes are none, go to DONE.
REQ-016 start SHALL be ignored in every state except IDLE; latched requests SHALL NOT change mid-sequence.
REQ-017 DROP_L: the servo selected by the latched left code = LEFT_SIDE, all others STATIONARY; dwell exactly HOLD_CYCLES cycles, then go to SETTLE_L.
REQ-018 SETTLE_L: all servos STATIONARY; dwell exactly SETTLE_CYCLES cycles. Then go to DROP_R if the right code is non-none and differs from the left code; otherwise go to DONE.
REQ-019 DROP_R / SETTLE_R mirror DROP_L / SETTLE_L using RIGHT_SIDE; SETTLE_R then goes to DONE.
REQ-020 At most one servo SHALL be off STATIONARY in any cycle.
REQ-021 Same non-none code on both sides: only the left drop is served, and conflict<=1 at the start-accept cycle. conflict clears only on reset.
REQ-022 DONE lasts one cycle: done=1, busy<=0, go<=1, then return to IDLE.
REQ-023 All outputs SHALL be registered. pos_* change in the first cycle of the new state.
REQ-024 Dwell counter: 27-bit, loaded on state entry, counts down to 0; no wrap permitted.
REQ-025 In IDLE, pos_* SHALL be STATIONARY.

Reset
REQ-026 On reset: state=IDLE, pos_*=STATIONARY, busy=0, done=0, go=1, conflict=0, dwell counter=0, latched codes=00.
REQ-027 Reset mid-sequence SHALL abort on the next clk edge and return all servos to STATIONARY; no done pulse is produced.

Structure
REQ-028 The mail code localparams (NONE, HZ10, HZ100, HZ1K) and the pulse constants SHALL live in shared package mail_pkg, which is also used by the mail delivery and PWM blocks.
REQ-029 The dwell timer SHALL be sub-module dwell_timer (load, value, expired).
REQ-030 Code-to-servo selection is combinational; state and outputs are sequential.

Verification (HOLD_CYCLES=10, SETTLE_CYCLES=5, start at cycle 0)
REQ-031 left=01, right=11 -> pos_10=100000 for cycles 1-10; all STATIONARY 11-15; pos_1k=205000 for 16-25; STATIONARY 26-30; done=1 and go=1 at cycle 31.
REQ-032 left=00, right=00 -> done=1 at cycle 1, pos_* never leave 150000, busy high only at cycle 1.
REQ-033 left=10, right=10 -> conflict=1 from cycle 1; only pos_100=100000 for cycles 1-10; done at cycle 16.
REQ-034 Second start pulse at cycle 5 of a running sequence -> ignored; latched codes and timing unchanged.
REQ-035 reset asserted at cycle 7 during DROP_L -> cycle 8: pos_*=150000, busy=0, go=1, done never pulses.
REQ-036 left=00, right=01 -> pos_10=205000 for cycles 1-10; done at cycle 16.

Source files
------------

// File: rtl/mail_pkg.sv
// Shared mail-delivery definitions: mail codes, servo pulse constants, sequencer
// states and the code-to-servo selection helper.
package mail_pkg;

  localparam int POS_W   = 18;
  localparam int DWELL_W = 27;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] HZ10  = 2'b01;
  localparam logic [1:0] HZ100 = 2'b10;
  localparam logic [1:0] HZ1K  = 2'b11;

  localparam logic [POS_W-1:0] STATIONARY = 18'd150000;
  localparam logic [POS_W-1:0] RIGHT_SIDE = 18'd205000;
  localparam logic [POS_W-1:0] LEFT_SIDE  = 18'd100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DROP_L,
    ST_SETTLE_L,
    ST_DROP_R,
    ST_SETTLE_R,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [POS_W-1:0] p10;
    logic [POS_W-1:0] p100;
    logic [POS_W-1:0] p1k;
  } servo_pos_t;

  // Only the servo named by the code leaves STATIONARY; NONE moves nothing.
  function automatic servo_pos_t select_servo(input logic [1:0]       code,
                                              input logic [POS_W-1:0] angle);
    servo_pos_t p;
    p.p10  = STATIONARY;
    p.p100 = STATIONARY;
    p.p1k  = STATIONARY;
    case (code)
      HZ10:    p.p10  = angle;
      HZ100:   p.p100 = angle;
      HZ1K:    p.p1k  = angle;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module dwell_timer
  import mail_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expired
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // Counting stops at zero so the counter can never wrap.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/mail_drop_sequencer.sv
// Drop sequencer: at a delivery stop, swings the left-coded servo, settles,
// then swings the right-coded servo, settles, and releases the rover.
module mail_drop_sequencer
  import mail_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned SETTLE_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       req_left,
  input  logic [1:0]       req_right,
  output logic [POS_W-1:0] pos_10,
  output logic [POS_W-1:0] pos_100,
  output logic [POS_W-1:0] pos_1k,
  output logic             busy,
  output logic             done,
  output logic             go,
  output logic             conflict
);

  // Timer is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [DWELL_W-1:0] HOLD_LOAD   = DWELL_W'(HOLD_CYCLES - 1);
  localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);

  seq_state_e         state_q, state_d;
  logic [1:0]         code_l_q, code_l_d;
  logic [1:0]         code_r_q, code_r_d;
  logic               conflict_q, conflict_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               go_q, go_d;
  servo_pos_t         pos_q, pos_d;
  logic               load;
  logic [DWELL_W-1:0] load_val;
  logic               expired;

  dwell_timer u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .value   (load_val),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    code_l_d   = code_l_q;
    code_r_d   = code_r_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          code_l_d = req_left;
          code_r_d = req_right;
          if (req_left != NONE && req_left == req_right) conflict_d = 1'b1;
          if (req_left != NONE)       state_d = ST_DROP_L;
          else if (req_right != NONE) state_d = ST_DROP_R;
          else                        state_d = ST_DONE;
        end
      end
      ST_DROP_L:   if (expired) state_d = ST_SETTLE_L;
      ST_SETTLE_L: begin
        if (expired) begin
          if (code_r_q != NONE && code_r_q != code_l_q) state_d = ST_DROP_R;
          else                                          state_d = ST_DONE;
        end
      end
      ST_DROP_R:   if (expired) state_d = ST_SETTLE_R;
      ST_SETTLE_R: if (expired) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    load = (state_d != state_q);
    case (state_d)
      ST_DROP_L, ST_DROP_R:     load_val = HOLD_LOAD;
      ST_SETTLE_L, ST_SETTLE_R: load_val = SETTLE_LOAD;
      default:                  load_val = '0;
    endcase

    // Outputs follow the next state so they change on the state's first cycle.
    case (state_d)
      ST_DROP_L: pos_d = select_servo(code_l_d, LEFT_SIDE);
      ST_DROP_R: pos_d = select_servo(code_r_d, RIGHT_SIDE);
      default:   pos_d = select_servo(NONE, STATIONARY);
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    go_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_l_q    <= NONE;
      code_r_q    <= NONE;
      conflict_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      go_q        <= 1'b1;
      pos_q.p10   <= STATIONARY;
      pos_q.p100  <= STATIONARY;
      pos_q.p1k   <= STATIONARY;
    end else begin
      state_q     <= state_d;
      code_l_q    <= code_l_d;
      code_r_q    <= code_r_d;
      conflict_q  <= conflict_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      go_q        <= go_d;
      pos_q       <= pos_d;
    end
  end

  assign pos_10   = pos_q.p10;
  assign pos_100  = pos_q.p100;
  assign pos_1k   = pos_q.p1k;
  assign busy     = busy_q;
  assign done     = done_q;
  assign go       = go_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_mail_drop_sequencer.sv
// Directed bench for mail_drop_sequencer with HOLD_CYCLES=10, SETTLE_CYCLES=5.
module tb_mail_drop_sequencer;

  localparam logic [17:0] S = 18'd150000;
  localparam logic [17:0] L = 18'd100000;
  localparam logic [17:0] R = 18'd205000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  req_left = 2'b00;
  logic [1:0]  req_right = 2'b00;
  logic [17:0] pos_10, pos_100, pos_1k;
  logic        busy, done, go, conflict;

  int n_vec = 0;
  int n_err = 0;

  mail_drop_sequencer #(.HOLD_CYCLES(10), .SETTLE_CYCLES(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .req_left  (req_left),
    .req_right (req_right),
    .pos_10    (pos_10),
    .pos_100   (pos_100),
    .pos_1k    (pos_1k),
    .busy      (busy),
    .done      (done),
    .go        (go),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [57:0] pk(input logic [17:0] p10, input logic [17:0] p100,
                                     input logic [17:0] p1k, input logic b, input logic d,
                                     input logic g, input logic c);
    return {p10, p100, p1k, b, d, g, c};
  endfunction

  function automatic logic [57:0] observed();
    return {pos_10, pos_100, pos_1k, busy, done, go, conflict};
  endfunction

  // Ends on a negedge with reset released; the next posedge is "edge 0".
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [57:0] exp;
    do_reset();
    exp = pk(S, S, S, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (observed() !== exp) begin
      n_err++;
      $display("FAIL reset_state got=%h want=%h", observed(), exp);
    end
  endtask

  task automatic test_left_right();
    logic [57:0] exp;
    do_reset();
    start = 1'b1; req_left = 2'b01; req_right = 2'b11;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 1'b0; req_left = 2'b10; req_right = 2'b10;
      exp = pk((c >= 1 && c <= 10) ? L : S, S, (c >= 16 && c <= 25) ? R : S,
               (c <= 31), (c == 31), (c >= 31), 1'b0);
      n_vec++;
      if (observed() !== exp) begin
        n_err++;
        $display("FAIL left_right cycle %0d got=%h want=%h", c, observed(), exp);
      end
    end
  endtask

  task automatic test_both_none();
    logic [57:0] exp;
    do_reset();
    start = 1'b1; req_left = 2'b00; req_right = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp = pk(S, S, S, (c == 1), (c == 1), 1'b1, 1'b0);
      n_vec++;
      if (observed() !== exp) begin
        n_err++;
        $display("FAIL both_none cycle %0d got=%h want=%h", c, observed(), exp);
      end
    end
  endtask

  task automatic test_right_only();
    logic [57:0] exp;
    do_reset();
    start = 1'b1; req_left = 2'b00; req_right = 2'b01;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp = pk((c <= 10) ? R : S, S, S, (c <= 16), (c == 16), (c >= 16), 1'b0);
      n_vec++;
      if (observed() !== exp) begin
        n_err++;
        $display("FAIL right_only cycle %0d got=%h want=%h", c, observed(), exp);
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [57:0] exp;
    do_reset();
    start = 1'b1; req_left = 2'b01; req_right = 2'b11;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp = pk((c <= 10) ? L : S, S, (c >= 16 && c <= 25) ? R : S,
               (c <= 31), (c == 31), (c >= 31), 1'b0);
      n_vec++;
      if (observed() !== exp) begin
        n_err++;
        $display("FAIL restart_ignored cycle %0d got=%h want=%h", c, observed(), exp);
      end
      if (c == 5) begin
        start = 1'b1; req_left = 2'b10; req_right = 2'b10;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [57:0] exp;
    do_reset();
    start = 1'b1; req_left = 2'b01; req_right = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 7) exp = pk(L, S, S, 1'b1, 1'b0, 1'b0, 1'b0);
      else        exp = pk(S, S, S, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (observed() !== exp) begin
        n_err++;
        $display("FAIL reset_mid cycle %0d got=%h want=%h", c, observed(), exp);
      end
      if (c == 7) reset = 1'b1;
      if (c == 8) reset = 1'b0;
    end
  endtask

  task automatic test_conflict();
    logic [57:0] exp;
    do_reset();
    start = 1'b1; req_left = 2'b10; req_right = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0; req_left = 2'b00; req_right = 2'b00;
      exp = pk(S, (c <= 10) ? L : S, S, (c <= 16), (c == 16), (c >= 16), 1'b1);
      n_vec++;
      if (observed() !== exp) begin
        n_err++;
        $display("FAIL conflict cycle %0d got=%h want=%h", c, observed(), exp);
      end
    end
    do_reset();
    n_vec++;
    if (conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_clear got=%b want=0", conflict);
    end
  endtask

  initial begin
    test_reset();
    test_left_right();
    test_both_none();
    test_right_only();
    test_restart_ignored();
    test_reset_mid();
    test_conflict();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
